ysyx_24080006_mdu_ctrl: RTL and testbench
=========================================

Name: ysyx_24080006_mdu_ctrl

Overview:
- Multi-cycle M-extension sequencer for the EXU: radix-2 shift-add multiply and restoring divide, 32 iterations.
- Owns no adder. Borrows the ALU's 34-bit adder through the mdu2alu_t / alu2mdu_t path, one add/sub per granted cycle.
- Accepts a decoded mdu_set_t plus operands. Returns one 32-bit result via valid/ready.

Parameters:
- ITER, 32, iteration count; equals operand width, fixed.

Ports:
- clock  in  1  core clock
- rst_n  in  1  reset; synchronous, active-low
- flush  in  1  abort current op (pipeline redirect)
- in_valid  in  1  request valid
- in_ready  out  1  controller idle, can accept
- mdu_set  in  mdu_set_t  {mdu_enable, signed_a, signed_b, mdu_op}
- rs1  in  32  operand A
- rs2  in  32  operand B
- alu_req  out  1  request ownership of the ALU adder this cycle
- alu_gnt  in  1  EXU yields the ALU adder this cycle
- mdu2alu  out  mdu2alu_t  adder operands a, b (33-bit each)
- alu_sub  out  1  1: res_34 = a - b; 0: res_34 = a + b (33-bit operands sign-extended to 34)
- alu2mdu  in  alu2mdu_t  adder result res_34, res_32 = res_34[31:0], not_zero
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- result  out  32  MULL/MULH/DIV/REM result

Behaviour:
- Reset (rst_n=0 at posedge) → state IDLE. Outputs: in_ready=1, out_valid=0, alu_req=0, result=0, mdu2alu=0, alu_sub=0. All datapath registers cleared.
- States: IDLE, NEG_A, NEG_B, ITER, FIX_LO, FIX_HI, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid & mdu_set.mdu_enable. Latch op, signs, operands.
  - neg_a = signed_a & rs1[31]; neg_b = signed_b & rs2[31].
  - Next state: NEG_A if neg_a, else NEG_B if neg_b, else ITER.
  - in_valid with mdu_enable=0 is ignored.
- NEG_A / NEG_B: a=0, b=operand, alu_sub=1; latch res_32 as magnitude.
- ITER: 5-bit counter runs 0..31; exits to FIX or DONE on count 31.
  - MUL: a = hi (33b, zero-ext); b = mcand if lo[0] else 0; add. {hi,lo} ← {res_34[32:0], lo} >> 1.
  - DIV: trial rem = {rem[31:0], dvd[31]}; a = trial; b = divisor; sub. res_34[33]=0 → rem = res_32, q bit = 1; else rem = trial, q bit = 0. Quotient shifts in from LSB.
- Sign fix:
  - MUL: sign = neg_a^neg_b. MULL → FIX_LO only. MULH → FIX_LO then FIX_HI.
  - FIX_LO: lo = 0 - lo; register lo_zero = !not_zero.
  - FIX_HI: a = ~hi, b = lo_zero, add.
  - DIV: quotient negated if neg_a^neg_b. REM: remainder negated if neg_a. One FIX_LO cycle.
  - No fix needed → DONE directly.
- Divide by zero (rs2 == 0): quotient = 0xFFFFFFFF, remainder = rs1. Quotient sign fix suppressed. Overflow 0x80000000 / -1 → q = 0x80000000, r = 0, falls out naturally.
- ALU sharing:
  - alu_req=1 in NEG_A, NEG_B, ITER, FIX_LO, FIX_HI. MUL iterations request even when lo[0]=0.
  - A state advances, and registers update, only in a cycle with alu_gnt=1. Otherwise all state holds.
  - alu_gnt ignored when alu_req=0.
- Latency with alu_gnt tied 1, accept at cycle 0: unsigned op → out_valid at cycle 33. Add 1 per negated operand, 1 per fix cycle. Signed MULH, both operands negative: cycle 35, sign=0, no fix.
- DONE: out_valid=1; result stable until out_ready; then IDLE. No new accept in the DONE→IDLE cycle.
- flush in any state → IDLE next cycle: out_valid=0, alu_req=0, result dropped. flush overrides out_ready and in_valid in the same cycle.
- rst_n low mid-op: same as flush plus register clear.

Optional Feature:
- MDU_EARLY_OUT_EN defined:
  - At accept, rs2==0 for DIV/REM, or rs1==0 / rs2==0 for MULL/MULH → NEG/ITER/FIX skipped.
  - DONE reached next cycle: out_valid at cycle 1. Results: 0xFFFFFFFF, rs1, or 0.
  - No ALU request issued.
- Undefined: these cases run full iterations with identical results.

Test Plan:
- MULL rs1=7, rs2=6, unsigned, gnt=1 → out_valid at cycle 33, result=42.
- MULH signed rs1=0xFFFFFFFF (-1), rs2=0x00000002 → result=0xFFFFFFFF. MULL same operands → 0xFFFFFFFE.
- DIV signed rs1=-7 (0xFFFFFFF9), rs2=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF.
- DIV rs1=0x12345678, rs2=0 → 0xFFFFFFFF; REM → 0x12345678. Signed DIV rs1=0x80000000, rs2=0xFFFFFFFF → 0x80000000.
- alu_gnt toggles 1,0 every cycle on unsigned MULL 3×5 → state frozen on gnt=0 cycles; result=15 at cycle 65.
- flush asserted mid-ITER (count=10) → IDLE next cycle, no out_valid, alu_req=0. Next request completes correctly. out_ready held 0 for 5 cycles in DONE → result stable.

Source files
------------

// File: rtl/ysyx_24080006_mdu_ctrl.sv
// M-extension sequencer: shift-add multiply / restoring divide on the borrowed ALU adder.
// Optional: define MDU_EARLY_OUT_EN to short-circuit zero-operand multiplies and divide-by-zero.
package ysyx_24080006_mdu_pkg;

   localparam logic [1:0] MDU_MULL = 2'd0;
   localparam logic [1:0] MDU_MULH = 2'd1;
   localparam logic [1:0] MDU_DIV  = 2'd2;
   localparam logic [1:0] MDU_REM  = 2'd3;

   typedef struct packed {
      logic       mdu_enable;
      logic       signed_a;
      logic       signed_b;
      logic [1:0] mdu_op;
   } mdu_set_t;

   typedef struct packed {
      logic [32:0] a;
      logic [32:0] b;
   } mdu2alu_t;

   typedef struct packed {
      logic [33:0] res_34;
      logic [31:0] res_32;
      logic        not_zero;
   } alu2mdu_t;

endpackage

module ysyx_24080006_mdu_ctrl
   import ysyx_24080006_mdu_pkg::*;
#(
   parameter int ITER = 32
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  mdu_set_t    mdu_set,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic        alu_req,
   input  logic        alu_gnt,
   output mdu2alu_t    mdu2alu,
   output logic        alu_sub,
   input  alu2mdu_t    alu2mdu,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result
);

   localparam int CW = $clog2(ITER);
   localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_NEG_A,
      S_NEG_B,
      S_ITER,
      S_FIX_LO,
      S_FIX_HI,
      S_DONE
   } state_t;

   state_t        state, state_d;
   logic [1:0]    op, op_d;
   logic          neg_a, neg_a_d;
   logic          neg_b, neg_b_d;
   logic          div_zero, div_zero_d;
   logic          lo_zero, lo_zero_d;
   logic [31:0]   hi, hi_d;
   logic [31:0]   lo, lo_d;
   logic [31:0]   bv, bv_d;
   logic [CW-1:0] cnt, cnt_d;

   logic          acc_neg_a;
   logic          acc_neg_b;
   logic          is_mul;
   logic          need_fix;
   logic [32:0]   trial;
   logic          q_bit;

   assign acc_neg_a = mdu_set.signed_a & rs1[31];
   assign acc_neg_b = mdu_set.signed_b & rs2[31];
   assign is_mul    = ~op[1];

   // Divide-by-zero keeps the all-ones quotient regardless of operand signs.
   always_comb begin
      need_fix = 1'b0;
      unique case (op)
         MDU_MULL, MDU_MULH: need_fix = neg_a ^ neg_b;
         MDU_DIV:            need_fix = (neg_a ^ neg_b) & ~div_zero;
         MDU_REM:            need_fix = neg_a;
         default:            need_fix = 1'b0;
      endcase
   end

`ifdef MDU_EARLY_OUT_EN
   logic early;
   assign early = mdu_set.mdu_op[1] ? (rs2 == '0)
                                    : ((rs1 == '0) | (rs2 == '0));
`endif

   always_comb begin
      state_d    = state;
      op_d       = op;
      neg_a_d    = neg_a;
      neg_b_d    = neg_b;
      div_zero_d = div_zero;
      lo_zero_d  = lo_zero;
      hi_d       = hi;
      lo_d       = lo;
      bv_d       = bv;
      cnt_d      = cnt;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      alu_req    = 1'b0;
      alu_sub    = 1'b0;
      mdu2alu    = '0;
      result     = '0;
      trial      = {hi, lo[31]};
      q_bit      = 1'b0;

      unique case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid & mdu_set.mdu_enable & ~flush) begin
               op_d       = mdu_set.mdu_op;
               neg_a_d    = acc_neg_a;
               neg_b_d    = acc_neg_b;
               div_zero_d = (rs2 == '0);
               lo_zero_d  = 1'b0;
               hi_d       = '0;
               lo_d       = rs1;
               bv_d       = rs2;
               cnt_d      = '0;
               if (acc_neg_a)
                  state_d = S_NEG_A;
               else if (acc_neg_b)
                  state_d = S_NEG_B;
               else
                  state_d = S_ITER;
`ifdef MDU_EARLY_OUT_EN
               if (early) begin
                  state_d = S_DONE;
                  if (mdu_set.mdu_op[1]) begin
                     lo_d = '1;
                     hi_d = rs1;
                  end else begin
                     lo_d = '0;
                     hi_d = '0;
                  end
               end
`endif
            end
         end

         S_NEG_A: begin
            alu_req   = 1'b1;
            alu_sub   = 1'b1;
            mdu2alu.b = {1'b0, lo};
            if (alu_gnt) begin
               lo_d    = alu2mdu.res_32;
               state_d = neg_b ? S_NEG_B : S_ITER;
            end
         end

         S_NEG_B: begin
            alu_req   = 1'b1;
            alu_sub   = 1'b1;
            mdu2alu.b = {1'b0, bv};
            if (alu_gnt) begin
               bv_d    = alu2mdu.res_32;
               state_d = S_ITER;
            end
         end

         S_ITER: begin
            alu_req = 1'b1;
            if (is_mul) begin
               mdu2alu.a = {1'b0, hi};
               mdu2alu.b = lo[0] ? {1'b0, bv} : '0;
            end else begin
               alu_sub   = 1'b1;
               mdu2alu.a = trial;
               mdu2alu.b = {1'b0, bv};
            end
            if (alu_gnt) begin
               if (is_mul) begin
                  hi_d = alu2mdu.res_34[32:1];
                  lo_d = {alu2mdu.res_34[0], lo[31:1]};
               end else begin
                  // Non-negative difference means the divisor fits.
                  q_bit = ~alu2mdu.res_34[33];
                  hi_d  = q_bit ? alu2mdu.res_32 : trial[31:0];
                  lo_d  = {lo[30:0], q_bit};
               end
               cnt_d = cnt + 1'b1;
               if (cnt == CNT_LAST)
                  state_d = need_fix ? S_FIX_LO : S_DONE;
            end
         end

         S_FIX_LO: begin
            alu_req   = 1'b1;
            alu_sub   = 1'b1;
            mdu2alu.b = {1'b0, (op == MDU_REM) ? hi : lo};
            if (alu_gnt) begin
               if (op == MDU_REM)
                  hi_d = alu2mdu.res_32;
               else
                  lo_d = alu2mdu.res_32;
               lo_zero_d = ~alu2mdu.not_zero;
               state_d   = (op == MDU_MULH) ? S_FIX_HI : S_DONE;
            end
         end

         // Upper word of a 64-bit negate: ~hi plus carry out of the low word.
         S_FIX_HI: begin
            alu_req   = 1'b1;
            mdu2alu.a = {1'b0, ~hi};
            mdu2alu.b = {32'd0, lo_zero};
            if (alu_gnt) begin
               hi_d    = alu2mdu.res_32;
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            out_valid = 1'b1;
            result    = (op == MDU_MULH || op == MDU_REM) ? hi : lo;
            if (out_ready)
               state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      if (flush)
         state_d = S_IDLE;
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         op       <= '0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         div_zero <= 1'b0;
         lo_zero  <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         bv       <= '0;
         cnt      <= '0;
      end else begin
         state    <= state_d;
         op       <= op_d;
         neg_a    <= neg_a_d;
         neg_b    <= neg_b_d;
         div_zero <= div_zero_d;
         lo_zero  <= lo_zero_d;
         hi       <= hi_d;
         lo       <= lo_d;
         bv       <= bv_d;
         cnt      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_ysyx_24080006_mdu_ctrl.sv
// Scoreboard bench for the MDU sequencer with a behavioural shared-adder model.
// Expected results and latencies are hand-computed; MDU_EARLY_OUT_EN shortens zero cases.
module tb_ysyx_24080006_mdu_ctrl;
   import ysyx_24080006_mdu_pkg::*;

`ifdef MDU_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   mdu_set_t    mdu_set;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        alu_req;
   logic        alu_gnt;
   mdu2alu_t    mdu2alu;
   logic        alu_sub;
   alu2mdu_t    alu2mdu;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   ysyx_24080006_mdu_ctrl dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mdu_set   (mdu_set),
      .rs1       (rs1),
      .rs2       (rs2),
      .alu_req   (alu_req),
      .alu_gnt   (alu_gnt),
      .mdu2alu   (mdu2alu),
      .alu_sub   (alu_sub),
      .alu2mdu   (alu2mdu),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   bit gnt_toggle = 1'b0;
   int gnt_base = 0;
   assign alu_gnt = !gnt_toggle || (((cyc - gnt_base) % 2) == 0);

   logic [33:0] sa, sb, sr;
   always_comb begin
      sa = {mdu2alu.a[32], mdu2alu.a};
      sb = {mdu2alu.b[32], mdu2alu.b};
      sr = alu_sub ? sa - sb : sa + sb;
      alu2mdu.res_34   = sr;
      alu2mdu.res_32   = sr[31:0];
      alu2mdu.not_zero = |sr[31:0];
   end

   typedef struct {
      logic [31:0] res;
      int          cyc;
      int          hold;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   chk_cnt = 0;
   int   pass_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      chk_cnt++;
      if (act === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic mdu_set_t mk(input logic [1:0] op, input bit sgn);
      mdu_set_t s;
      s.mdu_enable = 1'b1;
      s.signed_a   = sgn;
      s.signed_b   = sgn;
      s.mdu_op     = op;
      return s;
   endfunction

   task automatic issue(input mdu_set_t s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat, input int hold, input bit tog,
                        input bit push, input string name,
                        output int acc);
      int n;
      n = 0;
      @(negedge clock);
      while (!in_ready && n < 300) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) begin
         chk_cnt++;
         $display("FAIL %s_idle_wait: in_ready %b required 1", name, in_ready);
      end
      acc        = cyc;
      gnt_toggle = tog;
      gnt_base   = cyc;
      mdu_set    = s;
      rs1        = a;
      rs2        = b;
      in_valid   = 1'b1;
      if (push)
         sb_q.push_back('{exp, cyc + lat, hold, name});
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      mdu_set  = '0;
   endtask

   bit seen = 1'b0;
   int hold_left = 0;

   initial begin
      out_ready = 1'b0;
      forever begin
         @(negedge clock);
         if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk_cnt++;
               $display("FAIL unexpected_valid: result %h with no request pending",
                        result);
               out_ready = 1'b1;
            end else begin
               if (!seen) begin
                  chk({sb_q[0].name, "_cycle"}, 32'(cyc), 32'(sb_q[0].cyc));
                  seen      = 1'b1;
                  hold_left = sb_q[0].hold;
               end
               chk({sb_q[0].name, "_result"}, result, sb_q[0].res);
               if (hold_left > 0) begin
                  hold_left--;
                  out_ready = 1'b0;
               end else begin
                  out_ready = 1'b1;
                  void'(sb_q.pop_front());
                  seen = 1'b0;
               end
            end
         end else begin
            out_ready = 1'b0;
         end
      end
   end

   typedef struct {
      logic [1:0]  op;
      bit          sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int acc;
      int n;
      rst_n    = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      mdu_set  = '0;
      rs1      = '0;
      rs2      = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_alu_req", {31'd0, alu_req}, 32'd0);
      chk("rst_alu_sub", {31'd0, alu_sub}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_mdu2alu_b", mdu2alu.b[31:0], 32'd0);
      rst_n = 1'b1;

      // Request without mdu_enable must not start anything.
      @(negedge clock);
      mdu_set        = mk(MDU_MULL, 1'b0);
      mdu_set.mdu_enable = 1'b0;
      rs1            = 32'd3;
      rs2            = 32'd4;
      in_valid       = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      mdu_set  = '0;
      @(negedge clock);
      chk("disabled_in_ready", {31'd0, in_ready}, 32'd1);
      chk("disabled_alu_req", {31'd0, alu_req}, 32'd0);

      vecs.push_back('{MDU_MULL, 1'b0, 32'd7, 32'd6, 32'd42, 33, "mull_7x6"});
      vecs.push_back('{MDU_MULH, 1'b1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 36, "mulh_m1x2"});
      vecs.push_back('{MDU_MULL, 1'b1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 35, "mull_m1x2"});
      vecs.push_back('{MDU_DIV, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35, "div_m7_2"});
      vecs.push_back('{MDU_REM, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 35, "rem_m7_2"});
      vecs.push_back('{MDU_DIV, 1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF,
                       EARLY ? 1 : 33, "div_by0"});
      vecs.push_back('{MDU_REM, 1'b1, 32'h12345678, 32'd0, 32'h12345678,
                       EARLY ? 1 : 33, "rem_by0"});
      vecs.push_back('{MDU_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 35, "div_ovf"});
      vecs.push_back('{MDU_MULH, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'd0, 35, "mulh_nn"});
      vecs.push_back('{MDU_DIV, 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 35, "div_7_m2"});
      vecs.push_back('{MDU_REM, 1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 34, "rem_7_m2"});
      vecs.push_back('{MDU_DIV, 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF,
                       EARLY ? 1 : 34, "div_m5_by0"});
      vecs.push_back('{MDU_REM, 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB,
                       EARLY ? 1 : 35, "rem_m5_by0"});
      vecs.push_back('{MDU_DIV, 1'b0, 32'd100, 32'd7, 32'd14, 33, "divu_100_7"});
      vecs.push_back('{MDU_REM, 1'b0, 32'd100, 32'd7, 32'd2, 33, "remu_100_7"});
      vecs.push_back('{MDU_MULH, 1'b0, 32'h80000000, 32'd4, 32'd2, 33, "mulhu_big"});
      vecs.push_back('{MDU_MULL, 1'b0, 32'd0, 32'd5, 32'd0,
                       EARLY ? 1 : 33, "mull_zero"});

      foreach (vecs[i])
         issue(mk(vecs[i].op, vecs[i].sgn), vecs[i].a, vecs[i].b,
               vecs[i].res, vecs[i].lat, 0, 1'b0, 1'b1, vecs[i].name, acc);

      issue(mk(MDU_MULL, 1'b0), 32'd3, 32'd5, 32'd15, 65, 0, 1'b1, 1'b1,
            "mull_gnt_toggle", acc);

      // Abort a multiply at iteration 10; nothing may come out of it.
      issue(mk(MDU_MULL, 1'b0), 32'd9, 32'd9, 32'd81, 33, 0, 1'b0, 1'b0,
            "mull_flushed", acc);
      n = 0;
      while (cyc != acc + 11 && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("flush_alu_req_before", {31'd0, alu_req}, 32'd1);
      flush = 1'b1;
      @(posedge clock);
      #1;
      flush = 1'b0;
      @(negedge clock);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_alu_req", {31'd0, alu_req}, 32'd0);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);

      issue(mk(MDU_MULH, 1'b0), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,
            33, 5, 1'b0, 1'b1, "mulhu_max_hold", acc);

      n = 0;
      while ((sb_q.size() != 0 || !in_ready) && n < 500) begin
         @(negedge clock);
         n++;
      end
      if (sb_q.size() != 0) begin
         chk_cnt++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0",
                  sb_q.size());
      end
      repeat (3) @(negedge clock);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d",
               chk_cnt, pass_cnt);
      $fatal(1);
   end

endmodule
